// File: rtl/hangman_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package hangman_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} arb_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way pick between player and host requesters.
// Define UART_ARB_HOST_PRIORITY_EN for fixed host priority instead of round-robin.
module arb_rr2 (
  input  logic play_valid,
  input  logic host_valid,
  input  logic last_host,
  output logic any_valid,
  output logic win_host
);

  assign any_valid = play_valid | host_valid;

`ifdef UART_ARB_HOST_PRIORITY_EN
  assign win_host = host_valid;
`else
  // On a tie the requester that did not own the last transfer wins.
  assign win_host = (play_valid && host_valid) ? !last_host : host_valid;
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between the player and host byte sources, with send timeout.
// Arbitration mode is chosen in arb_rr2 by UART_ARB_HOST_PRIORITY_EN.
module uart_tx_arbiter
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              play_valid,
  input  logic [BYTE_W-1:0] play_byte,
  output logic              play_ack,
  input  logic              host_valid,
  input  logic [BYTE_W-1:0] host_byte,
  output logic              host_ack,
  input  logic              tx_ready,
  output logic              tx_ctrl,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              busy,
  output logic              grant_host,
  output logic              tx_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_ctrl_q, tx_ctrl_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              play_ack_q, play_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              busy_q, busy_d;
  logic              grant_host_q, grant_host_d;
  logic              tx_err_q, tx_err_d;
  logic              any_valid;
  logic              win_host;

  arb_rr2 u_pick (
    .play_valid (play_valid),
    .host_valid (host_valid),
    .last_host  (grant_host_q),
    .any_valid  (any_valid),
    .win_host   (win_host)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_ctrl_d    = tx_ctrl_q;
    tx_byte_d    = tx_byte_q;
    play_ack_d   = 1'b0;
    host_ack_d   = 1'b0;
    grant_host_d = grant_host_q;
    tx_err_d     = tx_err_q;

    case (state_q)
      IDLE: begin
        tx_ctrl_d = 1'b0;
        if (tx_ready && any_valid) begin
          state_d      = SEND;
          tx_ctrl_d    = 1'b1;
          cnt_d        = '0;
          grant_host_d = win_host;
          if (win_host) begin
            tx_byte_d  = host_byte;
            host_ack_d = 1'b1;
          end else begin
            tx_byte_d  = play_byte;
            play_ack_d = 1'b1;
          end
        end
      end
      SEND: begin
        // tx_ctrl stays high for exactly TIMEOUT_CYCLES cycles before giving up.
        if (!tx_ready) begin
          tx_ctrl_d = 1'b0;
          cnt_d     = '0;
          state_d   = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          tx_ctrl_d = 1'b0;
          tx_err_d  = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (tx_ready) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tx_ctrl_q    <= 1'b0;
      tx_byte_q    <= '0;
      play_ack_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_host_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_ctrl_q    <= tx_ctrl_d;
      tx_byte_q    <= tx_byte_d;
      play_ack_q   <= play_ack_d;
      host_ack_q   <= host_ack_d;
      busy_q       <= busy_d;
      grant_host_q <= grant_host_d;
      tx_err_q     <= tx_err_d;
    end
  end

  assign play_ack   = play_ack_q;
  assign host_ack   = host_ack_q;
  assign tx_ctrl    = tx_ctrl_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign grant_host = grant_host_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; tx_ready is driven by hand as the uart model.
// Expectations follow UART_ARB_HOST_PRIORITY_EN when it is defined.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       nRst;
  logic       play_valid;
  logic [7:0] play_byte;
  logic       play_ack;
  logic       host_valid;
  logic [7:0] host_byte;
  logic       host_ack;
  logic       tx_ready;
  logic       tx_ctrl;
  logic [7:0] tx_byte;
  logic       busy;
  logic       grant_host;
  logic       tx_err;

  int passCount  = 0;
  int checkCount = 0;
  int highCount  = 0;
  logic expHost;

  uart_tx_arbiter dut (
    .clk        (clk),
    .nRst       (nRst),
    .play_valid (play_valid),
    .play_byte  (play_byte),
    .play_ack   (play_ack),
    .host_valid (host_valid),
    .host_byte  (host_byte),
    .host_ack   (host_ack),
    .tx_ready   (tx_ready),
    .tx_ctrl    (tx_ctrl),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .grant_host (grant_host),
    .tx_err     (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic pv, input logic [7:0] pb,
                               input logic hv, input logic [7:0] hb, input logic rdy);
    play_valid = pv;
    play_byte  = pb;
    host_valid = hv;
    host_byte  = hb;
    tx_ready   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'd0, observed}, {31'd0, expected});
  endtask

  // Two-cycle frame: SEND -> DRAIN -> GAP -> IDLE, with busy dropping once back in IDLE.
  task automatic finishTransfer(input string tag);
    tx_ready = 1'b0;
    step(1);
    checkFlag({tag, "_drain_ctrl"}, tx_ctrl, 1'b0);
    checkFlag({tag, "_drain_busy"}, busy, 1'b1);
    step(1);
    tx_ready = 1'b1;
    step(1);
    checkFlag({tag, "_gap_busy"}, busy, 1'b1);
    step(1);
    checkFlag({tag, "_idle_busy"}, busy, 1'b0);
    checkFlag({tag, "_idle_ctrl"}, tx_ctrl, 1'b0);
  endtask

  initial begin
    nRst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #1 nRst = 1'b0;
    #1;
    checkFlag("rst_tx_ctrl", tx_ctrl, 1'b0);
    checkOutput("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
    checkFlag("rst_play_ack", play_ack, 1'b0);
    checkFlag("rst_host_ack", host_ack, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_grant_host", grant_host, 1'b0);
    checkFlag("rst_tx_err", tx_err, 1'b0);
    step(2);
    nRst = 1'b1;
    step(1);

    // Single player byte
    applyStimulus(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    step(1);
    checkFlag("single_play_ack", play_ack, 1'b1);
    checkFlag("single_host_ack", host_ack, 1'b0);
    checkFlag("single_tx_ctrl", tx_ctrl, 1'b1);
    checkOutput("single_tx_byte", {24'd0, tx_byte}, 32'h41);
    checkFlag("single_busy", busy, 1'b1);
    checkFlag("single_grant", grant_host, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    step(1);
    checkFlag("single_ack_pulse", play_ack, 1'b0);
    checkFlag("single_ctrl_held", tx_ctrl, 1'b1);
    checkOutput("single_byte_held", {24'd0, tx_byte}, 32'h41);
    finishTransfer("single");
    checkOutput("single_byte_after", {24'd0, tx_byte}, 32'h41);

    // tx_ready low in IDLE holds off the grant
    applyStimulus(1'b1, 8'h52, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkFlag("rdylow_play_ack", play_ack, 1'b0);
      checkFlag("rdylow_tx_ctrl", tx_ctrl, 1'b0);
    end
    tx_ready = 1'b1;
    step(1);
    checkFlag("rdyhigh_play_ack", play_ack, 1'b1);
    checkFlag("rdyhigh_tx_ctrl", tx_ctrl, 1'b1);
    checkOutput("rdyhigh_tx_byte", {24'd0, tx_byte}, 32'h52);
    play_valid = 1'b0;
    finishTransfer("rdyhigh");

    // Withdrawn host request
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    step(1);
    host_valid = 1'b0;
    step(1);
    tx_ready = 1'b1;
    step(2);
    checkFlag("withdraw_host_ack", host_ack, 1'b0);
    checkFlag("withdraw_tx_ctrl", tx_ctrl, 1'b0);
    checkFlag("withdraw_busy", busy, 1'b0);
    checkFlag("withdraw_tx_err", tx_err, 1'b0);

    // Timeout: tx_ready never falls
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    step(1);
    checkFlag("timeout_play_ack", play_ack, 1'b1);
    highCount = tx_ctrl ? 1 : 0;
    play_valid = 1'b0;
    for (int i = 0; i < 1100 && tx_ctrl; i++) begin
      step(1);
      if (tx_ctrl) highCount++;
    end
    checkOutput("timeout_ctrl_cycles", 32'(highCount), 32'd1023);
    checkFlag("timeout_tx_err", tx_err, 1'b1);
    checkFlag("timeout_busy", busy, 1'b0);
    step(3);
    checkFlag("timeout_err_sticky", tx_err, 1'b1);
    checkFlag("timeout_no_regrant", tx_ctrl, 1'b0);

    // Next request after timeout is served, then reset lands in DRAIN
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    step(1);
    checkFlag("post_to_host_ack", host_ack, 1'b1);
    checkOutput("post_to_tx_byte", {24'd0, tx_byte}, 32'h33);
    checkFlag("post_to_grant", grant_host, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1);
    checkFlag("drain_busy", busy, 1'b1);
    checkFlag("drain_tx_err", tx_err, 1'b1);
    #2 nRst = 1'b0;
    #1;
    checkFlag("midrst_tx_ctrl", tx_ctrl, 1'b0);
    checkFlag("midrst_busy", busy, 1'b0);
    checkFlag("midrst_tx_err", tx_err, 1'b0);
    checkFlag("midrst_grant", grant_host, 1'b0);
    checkOutput("midrst_tx_byte", {24'd0, tx_byte}, 32'h00);
    checkFlag("midrst_host_ack", host_ack, 1'b0);
    step(2);
    nRst = 1'b1;

    // Contention from reset: host first, then alternate (host only with priority)
    applyStimulus(1'b1, 8'h50, 1'b1, 8'h48, 1'b1);
    for (int i = 0; i < 4; i++) begin
`ifdef UART_ARB_HOST_PRIORITY_EN
      expHost = 1'b1;
`else
      expHost = (i % 2 == 0);
`endif
      step(1);
      checkFlag("contend_host_ack", host_ack, expHost);
      checkFlag("contend_play_ack", play_ack, !expHost);
      checkFlag("contend_grant", grant_host, expHost);
      checkOutput("contend_tx_byte", {24'd0, tx_byte}, expHost ? 32'h48 : 32'h50);
      finishTransfer("contend");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
